serv_mac_seq: RTL and testbench

//  Sequencer for the bit-serial ALU's two-pass multiply-accumulate flow.
//  - Accepts one MAC request per valid/ready handshake.
//  - Drives ALU enable, cnt0, sub, rd_sel and MAC_step2 through a carry-setup cycle plus a pass for each step.
//  - Pulses done when the accumulated result has been shifted out.
//  - Sits between the decoder/state logic and the ALU; owns the bit counter for MAC ops.

---
 rtl/serv_mac_seq.sv | 109 ++++++++++
 tb/tb_serv_mac_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_mac_seq.sv
// serv_mac_seq: sequencer for the bit-serial ALU two-pass multiply-accumulate.
// Flow: IDLE -> SETUP1 -> PASS1 -> SETUP2 -> PASS2 -> DONE -> IDLE.
// SETUP cycles leave the ALU disabled so it preloads its carry from o_alu_sub.
// Optional feature macro: SERV_MAC_ABORT_EN adds i_abort. The run is cancelled
// from SETUP1 through PASS2 and the sequencer returns to IDLE without a done pulse.
module serv_mac_seq #(
   parameter int W    = 1,
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic       i_mac_valid,
   output logic       o_mac_ready,
   input  logic       i_mac_sub,
   input  logic       i_stall,
`ifdef SERV_MAC_ABORT_EN
   input  logic       i_abort,
`endif
   output logic       o_alu_en,
   output logic       o_alu_cnt0,
   output logic       o_alu_sub,
   output logic [2:0] o_alu_rd_sel,
   output logic       o_alu_mac_step2,
   output logic       o_buf_we,
   output logic       o_rd_we,
   output logic       o_busy,
   output logic       o_done
);

   localparam int PLEN = XLEN / W;
   localparam int CW   = (PLEN > 1) ? $clog2(PLEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP1, S_PASS1, S_SETUP2, S_PASS2, S_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic           sub_r;
   logic           in_pass, last, run, abort;

   assign in_pass = (state == S_PASS1) || (state == S_PASS2);
   assign last    = (cnt == CW'(PLEN - 1));

`ifdef SERV_MAC_ABORT_EN
   // Abort only matters while an op is in flight; IDLE and DONE ignore it.
   assign abort = i_abort && (state != S_IDLE) && (state != S_DONE);
`else
   assign abort = 1'b0;
`endif

   // A pass cycle advances only when not stalled and not aborted.
   assign run = in_pass && !i_stall && !abort;

   // State register and latched subtract mode.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         sub_r <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && i_mac_valid)
            sub_r <= i_mac_sub;
      end
   end

   // Bit counter: held at zero outside the passes so each pass starts from 0.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt <= '0;
      else if (!in_pass)
         cnt <= '0;
      else if (run)
         cnt <= last ? '0 : cnt + 1'b1;
   end

   // Next-state logic; abort wins over stall.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (i_mac_valid) state_nxt = S_SETUP1;
         S_SETUP1: if (abort) state_nxt = S_IDLE;
                   else if (!i_stall) state_nxt = S_PASS1;
         S_PASS1:  if (abort) state_nxt = S_IDLE;
                   else if (run && last) state_nxt = S_SETUP2;
         S_SETUP2: if (abort) state_nxt = S_IDLE;
                   else if (!i_stall) state_nxt = S_PASS2;
         S_PASS2:  if (abort) state_nxt = S_IDLE;
                   else if (run && last) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output decode from state/count; i_mac_valid never reaches the ALU controls.
   always_comb begin
      o_mac_ready     = (state == S_IDLE);
      o_busy          = (state != S_IDLE);
      o_done          = (state == S_DONE);
      o_alu_en        = run;
      o_alu_cnt0      = in_pass && (cnt == '0) && !i_stall;
      o_alu_sub       = ((state == S_SETUP2) || (state == S_PASS2)) && sub_r;
      o_alu_rd_sel    = in_pass ? 3'b001 : 3'b000;
      o_alu_mac_step2 = (state == S_PASS2);
      o_buf_we        = run && (state == S_PASS1);
      o_rd_we         = run && (state == S_PASS2);
   end

endmodule

// File: tb/tb_serv_mac_seq.sv
// Testbench for serv_mac_seq: W=1 and W=4 instances share their inputs.
// Expected per-cycle control words are queued before each op is driven,
// then popped against the captured outputs.
module tb_serv_mac_seq;

   logic       clk = 1'b0;
   logic       rst_n, valid, sub, stall;
`ifdef SERV_MAC_ABORT_EN
   logic       abort;
`endif
   logic [1:0] ready, en, cnt0, asub, step2, buf_we, rd_we, busy, done;
   logic [2:0] rd_sel [2];

   int n_chk  = 0;
   int n_fail = 0;

   logic [11:0] exp_q[$];
   logic [11:0] obs_q[$];
   int          done_q[$];

   always #5 clk = ~clk;

   serv_mac_seq #(.W(1), .XLEN(32)) u1 (
      .clk(clk), .i_rst_n(rst_n), .i_mac_valid(valid), .o_mac_ready(ready[0]),
      .i_mac_sub(sub), .i_stall(stall),
`ifdef SERV_MAC_ABORT_EN
      .i_abort(abort),
`endif
      .o_alu_en(en[0]), .o_alu_cnt0(cnt0[0]), .o_alu_sub(asub[0]),
      .o_alu_rd_sel(rd_sel[0]), .o_alu_mac_step2(step2[0]), .o_buf_we(buf_we[0]),
      .o_rd_we(rd_we[0]), .o_busy(busy[0]), .o_done(done[0]));

   serv_mac_seq #(.W(4), .XLEN(32)) u4 (
      .clk(clk), .i_rst_n(rst_n), .i_mac_valid(valid), .o_mac_ready(ready[1]),
      .i_mac_sub(sub), .i_stall(stall),
`ifdef SERV_MAC_ABORT_EN
      .i_abort(abort),
`endif
      .o_alu_en(en[1]), .o_alu_cnt0(cnt0[1]), .o_alu_sub(asub[1]),
      .o_alu_rd_sel(rd_sel[1]), .o_alu_mac_step2(step2[1]), .o_buf_we(buf_we[1]),
      .o_rd_we(rd_we[1]), .o_busy(busy[1]), .o_done(done[1]));

   // Control word: {en,cnt0,sub,rd_sel[2:0],step2,buf_we,rd_we,busy,done,ready}
   function automatic logic [11:0] obs(input int s);
      return {en[s], cnt0[s], asub[s], rd_sel[s], step2[s], buf_we[s], rd_we[s],
              busy[s], done[s], ready[s]};
   endfunction

   // Expected timeline for one op accepted at cycle 0; stall window is [ss, ss+sl).
   task automatic gen_exp(input bit s, input int plen, input int ss, input int sl,
                          output int n);
      logic [11:0] w;
      int c, k;
      bit st;
      c = 1;
      exp_q.push_back(12'b0000_0000_0100);          // SETUP1
      c++;
      for (int p = 0; p < 2; p++) begin
         k = 0;
         while (k < plen) begin
            st = (c >= ss) && (c < ss + sl);
            w = '0;
            w[11]  = !st;
            w[10]  = (k == 0) && !st;
            w[9]   = (p == 1) && s;
            w[8:6] = 3'b001;
            w[5]   = (p == 1);
            w[4]   = (p == 0) && !st;
            w[3]   = (p == 1) && !st;
            w[2]   = 1'b1;
            exp_q.push_back(w);
            if (!st) k++;
            c++;
         end
         if (p == 0) begin
            w = 12'b0000_0000_0100;                  // SETUP2
            w[9] = s;
            exp_q.push_back(w);
            c++;
         end
      end
      exp_q.push_back(12'b0000_0000_0110);          // DONE
      c++;
      exp_q.push_back(12'b0000_0000_0001);          // back to IDLE
      n = c;
   endtask

   // Drive one op (valid pulse) and capture ncyc cycles of outputs from instance sel.
   task automatic run_capture(input int sel, input bit s, input int ncyc,
                              input int ss, input int sl);
      @(posedge clk); #1;
      valid = 1'b1; sub = s;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk); #1;
         valid = 1'b0;
         stall = (c >= ss) && (c < ss + sl);
         @(negedge clk);
         obs_q.push_back(obs(sel));
      end
      stall = 1'b0;
   endtask

   task automatic idle_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b0; sub = 1'b0; stall = 1'b0;
`ifdef SERV_MAC_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_chk++;
         if (obs(s) !== 12'h001) begin
            n_fail++;
            $display("FAIL reset_state inst%0d got %b want %b", s, obs(s), 12'h001);
         end
      end
      // Start an op, then reset asynchronously in the middle of PASS1.
      @(posedge clk); #1 valid = 1'b1;
      @(posedge clk); #1 valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_chk++;
      if (obs(0) !== 12'h001) begin
         n_fail++;
         $display("FAIL async_reset got %b want %b", obs(0), 12'h001);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_chk++; n_fail++;
            $display("FAIL post_reset_idle cycle %0d done %b busy %b want 0 0", c, done[0], busy[0]);
         end
      end
      n_chk++;
      if (ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_ready got %b want 1", ready[0]);
      end
   endtask

   task automatic test_pass_w1();
      int n, dc;
      logic [11:0] e, o;
      gen_exp(1'b0, 32, 0, 0, n);
      run_capture(0, 1'b0, n, 0, 0);
      dc = -1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         if (o[1]) dc = c;
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL w1_trace cycle %0d got %b want %b", c, o, e);
         end
      end
      n_chk++;
      if (dc != 67) begin
         n_fail++;
         $display("FAIL w1_done_cycle got %0d want 67", dc);
      end
      idle_wait(2);
   endtask

   task automatic test_w4_sub();
      int n, dc;
      logic [11:0] e, o;
      gen_exp(1'b1, 8, 0, 0, n);
      run_capture(1, 1'b1, n, 0, 0);
      dc = -1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         if (o[1]) dc = c;
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL w4_trace cycle %0d got %b want %b", c, o, e);
         end
      end
      n_chk++;
      if (dc != 19) begin
         n_fail++;
         $display("FAIL w4_done_cycle got %0d want 19", dc);
      end
      idle_wait(60);   // let the W=1 copy of this op finish
   endtask

   task automatic test_stall();
      int n, dc, en1, en2;
      logic [11:0] e, o;
      gen_exp(1'b0, 32, 12, 5, n);
      run_capture(0, 1'b0, n, 12, 5);
      dc = -1; en1 = 0; en2 = 0;
      for (int c = 1; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         if (o[1]) dc = c;
         if (o[11] && !o[5]) en1++;
         if (o[11] && o[5]) en2++;
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stall_trace cycle %0d got %b want %b", c, o, e);
         end
      end
      n_chk++;
      if (dc != 72) begin
         n_fail++;
         $display("FAIL stall_done_cycle got %0d want 72", dc);
      end
      n_chk++;
      if (en1 != 32 || en2 != 32) begin
         n_fail++;
         $display("FAIL stall_en_count got %0d/%0d want 32/32", en1, en2);
      end
      idle_wait(2);
   endtask

   task automatic test_back_to_back();
      int d;
      done_q.push_back(67);
      done_q.push_back(135);
      @(posedge clk); #1 valid = 1'b1; sub = 1'b0;
      for (int c = 1; c <= 136; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done[0]) begin
            n_chk++;
            if (done_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_done got extra done at %0d want none", c);
            end else begin
               d = done_q.pop_front();
               if (d != c) begin
                  n_fail++;
                  $display("FAIL b2b_done got cycle %0d want %0d", c, d);
               end
            end
         end
         if (c == 68 || c == 69) begin
            n_chk++;
            if (ready[0] !== (c == 68) || busy[0] !== (c == 69)) begin
               n_fail++;
               $display("FAIL b2b_handoff cycle %0d ready %b busy %b want %b %b",
                        c, ready[0], busy[0], c == 68, c == 69);
            end
         end
      end
      valid = 1'b0;
      n_chk++;
      if (done_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_missing_done got %0d pending want 0", done_q.size());
         done_q.delete();
      end
      idle_wait(40);
   endtask

`ifdef SERV_MAC_ABORT_EN
   task automatic test_abort();
      int nrd, ndone;
      nrd = 0; ndone = 0;
      @(posedge clk); #1 valid = 1'b1; sub = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk); #1;
         valid = 1'b0;
         abort = (c == 38);
         @(negedge clk);
         if (rd_we[0]) nrd++;
         if (done[0]) ndone++;
         if (c == 38) begin
            n_chk++;
            if (en[0] !== 1'b0 || rd_we[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_cycle en %b rd_we %b want 0 0", en[0], rd_we[0]);
            end
         end
         if (c == 39) begin
            n_chk++;
            if (ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_idle ready %b busy %b want 1 0", ready[0], busy[0]);
            end
         end
      end
      abort = 1'b0;
      n_chk++;
      if (nrd != 3 || ndone != 0) begin
         n_fail++;
         $display("FAIL abort_counts rd_we %0d done %0d want 3 0", nrd, ndone);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_pass_w1();
      test_w4_sub();
      test_stall();
      test_back_to_back();
`ifdef SERV_MAC_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
